async_fifo: RTL and testbench

ASYNC_FIFO -- requirements
Module: async_fifo

---
 rtl/async_fifo_pkg.sv | 14 +
 rtl/async_fifo_mem.sv | 36 +++
 rtl/async_fifo.sv | 90 +++++++++
 tb/tb_async_fifo.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared defaults and pointer-width helper for the async_fifo block.
package async_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;

  // Pointers carry one extra bit so full and empty can be told apart.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  localparam int PTR_WIDTH_DEF = ptr_width(ADDR_WIDTH_DEF);

endpackage

// File: rtl/async_fifo_mem.sv
// FIFO storage: unreset array with a synchronous write port and a registered read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Only the output register is reset; the array itself keeps stale words.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO with extended-pointer full/empty detection.
// Optional sticky overflow/underflow outputs when ASYNC_FIFO_ERR_FLAGS_EN is defined.
module async_fifo
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  clk_wr,
  input  logic                  wrst,
  input  logic                  rd_en
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int PW = ptr_width(ADDR_WIDTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          wr_acc, rd_acc;

  assign empty  = (rd_ptr_q == wr_ptr_q);
  assign full   = (rd_ptr_q[PW-1] != wr_ptr_q[PW-1]) &&
                  (rd_ptr_q[PW-2:0] == wr_ptr_q[PW-2:0]);
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk_wr or posedge wrst) begin
    if (wrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk_i  (clk_wr),
    .rst_i  (wrst),
    .we_i   (wr_acc),
    .waddr_i(wr_ptr_q[PW-2:0]),
    .wdata_i(wr_data),
    .re_i   (rd_acc),
    .raddr_i(rd_ptr_q[PW-2:0]),
    .rdata_o(rd_data)
  );

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (wr_en & full);
    underflow_d = underflow_q | (rd_en & empty);
  end

  always_ff @(posedge clk_wr or posedge wrst) begin
    if (wrst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo: stimulus pushes expected words, a monitor checks reads.
module tb_async_fifo;

  localparam int DEPTH = 16;

  logic       clk_wr = 1'b0;
  logic       wrst;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       full;
  logic       empty;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  async_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .rd_data  (rd_data),
    .full     (full),
    .empty    (empty),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .clk_wr   (clk_wr),
    .wrst     (wrst),
    .rd_en    (rd_en)
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  always #5 clk_wr = ~clk_wr;

  int         total = 0;
  int         bad = 0;
  int         cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_rd = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: a read is presented whenever rd_en is high on a non-empty FIFO.
  initial begin
    forever begin
      logic [7:0] e;
      @(negedge clk_wr);
      if (wrst === 1'b0 && rd_en === 1'b1 && empty === 1'b0) begin
        @(posedge clk_wr);
        #2;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected: got %0h expected no read", rd_data);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e);
          last_rd = e;
        end
      end
    end
  end

  task automatic step(input logic we, input logic [7:0] wd, input logic re);
    logic aw, ar;
    aw = we && (cnt < DEPTH);
    ar = re && (cnt > 0);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    if (aw) exp_q.push_back(wd);
    @(posedge clk_wr);
    #1;
    cnt = cnt + int'(aw) - int'(ar);
    chk("empty", empty, cnt == 0);
    chk("full", full, cnt == DEPTH);
    if (!ar) chk("rd_hold", rd_data, last_rd);
  endtask

  task automatic do_reset(input int n, input logic re);
    wr_en = 1'b0;
    rd_en = re;
    wrst  = 1'b1;
    exp_q.delete();
    cnt = 0;
    last_rd = 8'h00;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rd_data", rd_data, 0);
    repeat (n) begin
      @(posedge clk_wr);
      #1;
    end
    chk("rst_hold_empty", empty, 1);
    chk("rst_hold_rd_data", rd_data, 0);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
`endif
    wrst = 1'b0;
  endtask

  initial begin
    wrst    = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b1;
    wr_data = 8'h00;
    @(posedge clk_wr);
    #1;
    do_reset(10, 1'b1);

    // rd_en held after reset on an empty FIFO changes nothing
    repeat (3) step(1'b0, 8'h00, 1'b1);

    // single transfer
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // fill, overflow attempt, drain, underflow attempt
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hFF, 1'b0);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    chk("overflow_set", overflow, 1);
    chk("underflow_clear", underflow, 0);
`endif
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    chk("underflow_set", underflow, 1);
    chk("overflow_sticky", overflow, 1);
`endif

    // wrap-around with alternating write/read pairs
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom), 1'b0);
      step(1'b0, 8'h00, 1'b1);
    end
    step(1'b0, 8'h00, 1'b0);

    // simultaneous read/write at count 5
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(8'h20 + i), 1'b1);
      chk("count5_hold", cnt, 5);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // simultaneous at empty: only the write lands
    step(1'b1, 8'h5A, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // simultaneous at full: only the read lands
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // reset mid-operation discards stored words
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    do_reset(2, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
